// File: rtl/cordic_prerotate.sv
// CORDIC input stage: folds angles outside [-90, +90) by a 180 degree pre-rotation
// with saturating negation, then passes results through a two-register skid pipeline.
module cordic_prerotate #(
   parameter int W     = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     x_in,
   input  logic [W-1:0]     y_in,
   input  logic [W-1:0]     z_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     x_out,
   output logic [W-1:0]     y_out,
   output logic [W-1:0]     z_out,
   output logic             flip_out,
   output logic             sat_out,
   output logic [TAG_W-1:0] tag_out
);

   localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

   function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
      logic signed [W-1:0] r;
      if (v == MOST_NEG) r = MOST_POS;
      else               r = -v;
      return r;
   endfunction

   logic                    flip;
   logic                    sat_fold;
   logic signed [W-1:0]     x_fold;
   logic signed [W-1:0]     y_fold;
   logic        [W-1:0]     z_fold;
   logic                    advance;

   logic                    s1_valid_q, s1_valid_d;
   logic signed [W-1:0]     s1_x_q, s1_x_d, s1_y_q, s1_y_d;
   logic        [W-1:0]     s1_z_q, s1_z_d;
   logic                    s1_flip_q, s1_flip_d, s1_sat_q, s1_sat_d;
   logic        [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic                    s2_valid_q, s2_valid_d;
   logic signed [W-1:0]     s2_x_q, s2_x_d, s2_y_q, s2_y_d;
   logic        [W-1:0]     s2_z_q, s2_z_d;
   logic                    s2_flip_q, s2_flip_d, s2_sat_q, s2_sat_d;
   logic        [TAG_W-1:0] s2_tag_q, s2_tag_d;

   logic        [TAG_W-1:0] tag_q, tag_d;

   // Fold: top two bits differing means the angle lies in [90, 270); adding 180 only flips the MSB.
   always_comb begin
      flip     = z_in[W-1] ^ z_in[W-2];
      x_fold   = flip ? neg_sat($signed(x_in)) : $signed(x_in);
      y_fold   = flip ? neg_sat($signed(y_in)) : $signed(y_in);
      z_fold   = {z_in[W-1] ^ flip, z_in[W-2:0]};
      sat_fold = flip && (($signed(x_in) == MOST_NEG) || ($signed(y_in) == MOST_NEG));
   end

   always_comb begin
      advance    = !s2_valid_q || out_ready;
      in_ready   = !s1_valid_q || advance;

      s1_valid_d = s1_valid_q;
      s1_x_d     = s1_x_q;
      s1_y_d     = s1_y_q;
      s1_z_d     = s1_z_q;
      s1_flip_d  = s1_flip_q;
      s1_sat_d   = s1_sat_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_x_d     = s2_x_q;
      s2_y_d     = s2_y_q;
      s2_z_d     = s2_z_q;
      s2_flip_d  = s2_flip_q;
      s2_sat_d   = s2_sat_q;
      s2_tag_d   = s2_tag_q;
      tag_d      = tag_q;

      if (advance) begin
         s2_valid_d = s1_valid_q;
         s2_x_d     = s1_x_q;
         s2_y_d     = s1_y_q;
         s2_z_d     = s1_z_q;
         s2_flip_d  = s1_flip_q;
         s2_sat_d   = s1_sat_q;
         s2_tag_d   = s1_tag_q;
      end

      if (in_ready) begin
         s1_valid_d = in_valid;
         s1_x_d     = x_fold;
         s1_y_d     = y_fold;
         s1_z_d     = z_fold;
         s1_flip_d  = flip;
         s1_sat_d   = sat_fold;
         s1_tag_d   = tag_q;
         if (in_valid) tag_d = tag_q + TAG_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_z_q     <= '0;
         s1_flip_q  <= 1'b0;
         s1_sat_q   <= 1'b0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_x_q     <= '0;
         s2_y_q     <= '0;
         s2_z_q     <= '0;
         s2_flip_q  <= 1'b0;
         s2_sat_q   <= 1'b0;
         s2_tag_q   <= '0;
         tag_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_x_q     <= s1_x_d;
         s1_y_q     <= s1_y_d;
         s1_z_q     <= s1_z_d;
         s1_flip_q  <= s1_flip_d;
         s1_sat_q   <= s1_sat_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_x_q     <= s2_x_d;
         s2_y_q     <= s2_y_d;
         s2_z_q     <= s2_z_d;
         s2_flip_q  <= s2_flip_d;
         s2_sat_q   <= s2_sat_d;
         s2_tag_q   <= s2_tag_d;
         tag_q      <= tag_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign x_out     = s2_x_q;
   assign y_out     = s2_y_q;
   assign z_out     = s2_z_q;
   assign flip_out  = s2_flip_q;
   assign sat_out   = s2_sat_q;
   assign tag_out   = s2_tag_q;

endmodule

// File: tb/tb_cordic_prerotate.sv
// Bench for cordic_prerotate: vector table, latency, backpressure, tag wrap,
// mid-stream reset and randomized traffic against a plain-arithmetic fold model.
module tb_cordic_prerotate;

   localparam int W     = 32;
   localparam int TAG_W = 8;

   typedef struct packed {
      logic [W-1:0]     x;
      logic [W-1:0]     y;
      logic [W-1:0]     z;
      logic             flip;
      logic             sat;
      logic [TAG_W-1:0] tag;
   } beat_t;

   typedef struct packed {
      logic [W-1:0] x, y, z;
      logic [W-1:0] ex, ey, ez;
      logic         ef, es;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     x_in = '0, y_in = '0, z_in = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [W-1:0]     x_out, y_out, z_out;
   logic             flip_out, sat_out;
   logic [TAG_W-1:0] tag_out;

   int tests = 0;
   int fails = 0;

   beat_t            exp_q[$];
   logic [TAG_W-1:0] tag_model = '0;
   logic             prev_stall = 1'b0;
   beat_t            held;

   cordic_prerotate #(.W(W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .x_out(x_out), .y_out(y_out), .z_out(z_out),
      .flip_out(flip_out), .sat_out(sat_out), .tag_out(tag_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: angle in [-90, +90) passes; otherwise negate with clamp and add 180 degrees.
   function automatic beat_t model(input logic [W-1:0] x, y, z, input logic [TAG_W-1:0] t);
      beat_t  b;
      longint zs, q, lim, nx, ny, zz;
      zs  = longint'($signed(z));
      q   = longint'(1) <<< (W-2);
      lim = (longint'(1) <<< (W-1)) - 1;
      b.tag = t;
      if (zs >= -q && zs < q) begin
         b.x = x; b.y = y; b.z = z; b.flip = 1'b0; b.sat = 1'b0;
      end else begin
         b.flip = 1'b1;
         b.sat  = 1'b0;
         nx = -longint'($signed(x));
         ny = -longint'($signed(y));
         if (nx > lim) begin nx = lim; b.sat = 1'b1; end
         if (ny > lim) begin ny = lim; b.sat = 1'b1; end
         zz = (longint'(z) + (longint'(1) <<< (W-1))) % (longint'(1) <<< W);
         b.x = nx[W-1:0];
         b.y = ny[W-1:0];
         b.z = zz[W-1:0];
      end
      return b;
   endfunction

   task automatic cycle(input logic iv, input logic [W-1:0] x, y, z, input logic ordy,
                        input logic use_exp, input beat_t exp_b, output logic acc);
      beat_t e;
      @(negedge clk);
      in_valid  = iv;
      x_in      = x;
      y_in      = y;
      z_in      = z;
      out_ready = ordy;
      #1;
      if (prev_stall) begin
         check("hold_valid", 64'(out_valid), 64'(1));
         check("hold_x", 64'(x_out), 64'(held.x));
         check("hold_y", 64'(y_out), 64'(held.y));
         check("hold_z", 64'(z_out), 64'(held.z));
         check("hold_tag", 64'(tag_out), 64'(held.tag));
      end
      acc = in_valid && in_ready;
      if (acc) begin
         e = use_exp ? exp_b : model(x, y, z, tag_model);
         exp_q.push_back(e);
         tag_model = tag_model + TAG_W'(1);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got beat tag %0h expected no beat", tag_out);
         end else begin
            e = exp_q.pop_front();
            check("out_x", 64'(x_out), 64'(e.x));
            check("out_y", 64'(y_out), 64'(e.y));
            check("out_z", 64'(z_out), 64'(e.z));
            check("out_flip", 64'(flip_out), 64'(e.flip));
            check("out_sat", 64'(sat_out), 64'(e.sat));
            check("out_tag", 64'(tag_out), 64'(e.tag));
         end
      end
      prev_stall = out_valid && !out_ready;
      held = '{x: x_out, y: y_out, z: z_out, flip: flip_out, sat: sat_out, tag: tag_out};
   endtask

   task automatic drain(input int n, input string nm);
      logic a;
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, a);
      check(nm, 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_x_out", 64'(x_out), 64'(0));
      check("rst_flip_sat", 64'({flip_out, sat_out}), 64'(0));
      exp_q.delete();
      tag_model  = '0;
      prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));
   endtask

   function automatic logic [W-1:0] pick_val();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'h8000_0000;
         1: v = 32'h7FFF_FFFF;
         2: v = 32'h4000_0000;
         3: v = 32'hBFFF_FFFF;
         4: v = 32'h3FFF_FFFF;
         5: v = 32'hC000_0000;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      vec_t  tbl[7];
      beat_t eb;
      logic  acc;
      logic  saw_block;
      int    sent;

      tbl[0] = '{32'h1000_0000, 32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2000_0000, 32'h2000_0000, 1'b0, 1'b0};
      tbl[1] = '{32'h1000_0000, 32'h0, 32'h6000_0000, 32'hF000_0000, 32'h0, 32'hE000_0000, 1'b1, 1'b0};
      tbl[2] = '{32'h8000_0000, 32'h5, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFB, 32'h0, 1'b1, 1'b1};
      tbl[3] = '{32'h1, 32'h2, 32'h3FFF_FFFF, 32'h1, 32'h2, 32'h3FFF_FFFF, 1'b0, 1'b0};
      tbl[4] = '{32'h3, 32'hFFFF_FFFC, 32'h4000_0000, 32'hFFFF_FFFD, 32'h4, 32'hC000_0000, 1'b1, 1'b0};
      tbl[5] = '{32'h8000_0000, 32'h7, 32'hC000_0000, 32'h8000_0000, 32'h7, 32'hC000_0000, 1'b0, 1'b0};
      tbl[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hBFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b1, 1'b1};

      #2;
      check("por_out_valid", 64'(out_valid), 64'(0));
      check("por_data", 64'({x_out, y_out} | 64'(z_out)), 64'(0));
      do_reset();

      // Table vectors streamed back to back; also checks the two-edge latency.
      for (int i = 0; i < 7; i++) begin
         eb = '{x: tbl[i].ex, y: tbl[i].ey, z: tbl[i].ez, flip: tbl[i].ef, sat: tbl[i].es, tag: TAG_W'(i)};
         cycle(1'b1, tbl[i].x, tbl[i].y, tbl[i].z, 1'b1, 1'b1, eb, acc);
         if (i == 1) check("latency_not_yet", 64'(out_valid), 64'(0));
         if (i == 2) check("latency_arrived", 64'(out_valid), 64'(1));
      end
      drain(4, "table_drained");

      // Backpressure: five beats, out_ready low during cycles 2-6.
      do_reset();
      sent = 0;
      saw_block = 1'b0;
      for (int i = 0; i < 14; i++) begin
         cycle(sent < 5, $urandom, $urandom, $urandom, !(i >= 2 && i <= 6), 1'b0, '0, acc);
         if (acc) sent++;
         if (!in_ready) saw_block = 1'b1;
      end
      check("bp_in_ready_fell", 64'(saw_block), 64'(1));
      check("bp_all_sent", 64'(sent), 64'(5));
      drain(4, "bp_drained");

      // Tag wrap across 257 consecutive beats.
      do_reset();
      for (int i = 0; i < 257; i++) cycle(1'b1, $urandom, $urandom, pick_val(), 1'b1, 1'b0, '0, acc);
      drain(4, "wrap_drained");

      // Reset with both stages full.
      do_reset();
      cycle(1'b1, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0, '0, acc);
      cycle(1'b1, 32'h44, 32'h55, 32'h66, 1'b0, 1'b0, '0, acc);
      cycle(1'b1, 32'h77, 32'h88, 32'h99, 1'b0, 1'b0, '0, acc);
      check("full_in_ready", 64'(in_ready), 64'(0));
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'(0));
      check("mid_rst_data", 64'({x_out, y_out}), 64'(0));
      check("mid_rst_z_tag", 64'({z_out, tag_out, flip_out, sat_out}), 64'(0));
      exp_q.delete();
      tag_model  = '0;
      prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 32'h1234, 32'h5678, 32'h7000_0000, 1'b1, 1'b0, '0, acc);
      drain(3, "mid_rst_drained");

      // Randomized traffic with random backpressure.
      do_reset();
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 3) != 0, pick_val(), pick_val(), pick_val(),
               $urandom_range(0, 2) != 0, 1'b0, '0, acc);
      drain(4, "rand_drained");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
